// File: rtl/ncpu32k_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : ncpu32k_bus_arb
// Purpose  : Shares one memory command/response port between the fetch bus
//            (ibus) and the load/store bus (dbus), one transaction in flight.
//            Define NCPU_BUS_ARB_RR_EN for round-robin; otherwise dbus wins.
// Revision : 1.0 - initial release
// ============================================================================
module ncpu32k_bus_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    // fetch bus
    input  logic            ibus_cmd_valid,
    output logic            ibus_cmd_ready,
    input  logic [AW-1:0]   ibus_cmd_addr,
    input  logic            ibus_flush_req,
    output logic            ibus_valid,
    input  logic            ibus_ready,
    output logic [DW-1:0]   ibus_dout,
    // load/store bus
    input  logic            dbus_cmd_valid,
    output logic            dbus_cmd_ready,
    input  logic [AW-1:0]   dbus_cmd_addr,
    input  logic [DW/8-1:0] dbus_cmd_we,
    input  logic [DW-1:0]   dbus_din,
    output logic            dbus_valid,
    input  logic            dbus_ready,
    output logic [DW-1:0]   dbus_dout,
    // memory port
    output logic            mem_cmd_valid,
    input  logic            mem_cmd_ready,
    output logic [AW-1:0]   mem_cmd_addr,
    output logic [DW/8-1:0] mem_cmd_we,
    output logic [DW-1:0]   mem_din,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [DW-1:0]   mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t r_state;
    logic   w_grant_d;
    logic   w_cmd_hs;
    logic   w_rsp_hs;

    assign w_cmd_hs = mem_cmd_valid & mem_cmd_ready;
    assign w_rsp_hs = mem_valid & mem_ready;

`ifdef NCPU_BUS_ARB_RR_EN
    // r_rr_ptr = 0 prefers ibus, 1 prefers dbus; it points at the loser
    // of each accepted command so contending requesters alternate.
    logic r_rr_ptr;

    assign w_grant_d = dbus_cmd_valid & (~ibus_cmd_valid | r_rr_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if ((r_state == S_IDLE) && w_cmd_hs) begin
            r_rr_ptr <= ~w_grant_d;
        end
    end
`else
    assign w_grant_d = dbus_cmd_valid;
`endif

    // Command path: winner muxed straight through; fetches never write.
    assign mem_cmd_addr = w_grant_d ? dbus_cmd_addr : ibus_cmd_addr;
    assign mem_cmd_we   = w_grant_d ? dbus_cmd_we   : '0;
    assign mem_din      = w_grant_d ? dbus_din      : '0;

    // Response data reaches only the owner recorded at command acceptance.
    assign ibus_dout = (r_state == S_BUSY_I) ? mem_dout : '0;
    assign dbus_dout = (r_state == S_BUSY_D) ? mem_dout : '0;

    always_comb begin
        mem_cmd_valid  = 1'b0;
        ibus_cmd_ready = 1'b0;
        dbus_cmd_ready = 1'b0;
        mem_ready      = 1'b0;
        ibus_valid     = 1'b0;
        dbus_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                mem_cmd_valid  = w_grant_d ? dbus_cmd_valid : ibus_cmd_valid;
                dbus_cmd_ready = w_grant_d & mem_cmd_ready;
                ibus_cmd_ready = ~w_grant_d & mem_cmd_ready;
            end
            S_BUSY_I: begin
                if (ibus_flush_req) begin
                    mem_ready = 1'b1;
                end else begin
                    ibus_valid = mem_valid;
                    mem_ready  = ibus_ready;
                end
            end
            S_BUSY_D: begin
                dbus_valid = mem_valid;
                mem_ready  = dbus_ready;
            end
            S_DRAIN: begin
                mem_ready = 1'b1;
            end
            default: begin
                mem_ready = 1'b0;
            end
        endcase
        if (rst) begin
            mem_cmd_valid  = 1'b0;
            ibus_cmd_ready = 1'b0;
            dbus_cmd_ready = 1'b0;
            mem_ready      = 1'b0;
            ibus_valid     = 1'b0;
            dbus_valid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_state <= w_grant_d ? S_BUSY_D : S_BUSY_I;
                    end
                end
                S_BUSY_I: begin
                    if (ibus_flush_req && !mem_valid) begin
                        r_state <= S_DRAIN;
                    end else if (w_rsp_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY_D: begin
                    if (w_rsp_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (mem_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ncpu32k_bus_arb.sv
`default_nettype none
// Testbench for ncpu32k_bus_arb: directed scenarios plus randomized traffic
// checked against a transaction-level model with its own memory array.
module tb_ncpu32k_bus_arb;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef NCPU_BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ibus_cmd_valid, ibus_cmd_ready, ibus_flush_req, ibus_valid, ibus_ready;
    logic [AW-1:0] ibus_cmd_addr;
    logic [DW-1:0] ibus_dout;
    logic          dbus_cmd_valid, dbus_cmd_ready, dbus_valid, dbus_ready;
    logic [AW-1:0] dbus_cmd_addr;
    logic [3:0]    dbus_cmd_we;
    logic [DW-1:0] dbus_din, dbus_dout;
    logic          mem_cmd_valid, mem_cmd_ready, mem_valid, mem_ready;
    logic [AW-1:0] mem_cmd_addr;
    logic [3:0]    mem_cmd_we;
    logic [DW-1:0] mem_din, mem_dout;

    int total = 0;
    int bad   = 0;

    ncpu32k_bus_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready),
        .ibus_cmd_addr(ibus_cmd_addr), .ibus_flush_req(ibus_flush_req),
        .ibus_valid(ibus_valid), .ibus_ready(ibus_ready), .ibus_dout(ibus_dout),
        .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
        .dbus_cmd_addr(dbus_cmd_addr), .dbus_cmd_we(dbus_cmd_we), .dbus_din(dbus_din),
        .dbus_valid(dbus_valid), .dbus_ready(dbus_ready), .dbus_dout(dbus_dout),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_we(mem_cmd_we), .mem_din(mem_din),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dout(mem_dout)
    );

    // {mem_cmd_valid, mem_ready, ibus_cmd_ready, ibus_valid, dbus_cmd_ready, dbus_valid}
    function automatic logic [5:0] hs_out();
        return {mem_cmd_valid, mem_ready, ibus_cmd_ready, ibus_valid, dbus_cmd_ready, dbus_valid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ibus_cmd_valid = 0; ibus_cmd_addr = '0; ibus_flush_req = 0; ibus_ready = 0;
        dbus_cmd_valid = 0; dbus_cmd_addr = '0; dbus_cmd_we = '0; dbus_din = '0; dbus_ready = 0;
        mem_cmd_ready = 0; mem_valid = 0; mem_dout = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        ibus_cmd_valid = 1; dbus_cmd_valid = 1; mem_cmd_ready = 1;
        mem_valid = 1; ibus_ready = 1; dbus_ready = 1;
        sample();
        total++;
        if (hs_out() !== 6'b000000) begin
            bad++; $display("FAIL reset_outputs: got %b want 000000", hs_out());
        end
        tick();
        rst = 0; clear_inputs();
        ibus_cmd_valid = 1; ibus_cmd_addr = 32'h40;
        sample();
        total++;
        if ({mem_cmd_valid, mem_cmd_addr} !== {1'b1, 32'h40}) begin
            bad++; $display("FAIL reset_idle: got %b/%h want 1/00000040", mem_cmd_valid, mem_cmd_addr);
        end
        tick(); clear_inputs();
    endtask

    task automatic test_ibus_fetch();
        ibus_cmd_valid = 1; ibus_cmd_addr = 32'h100; mem_cmd_ready = 1;
        sample();
        total++;
        if (hs_out() !== 6'b101000) begin
            bad++; $display("FAIL fetch_cmd_hs: got %b want 101000", hs_out());
        end
        total++;
        if ({mem_cmd_addr, mem_cmd_we, mem_din} !== {32'h100, 4'h0, 32'h0}) begin
            bad++; $display("FAIL fetch_cmd_fields: got %h/%h/%h want 00000100/0/00000000",
                            mem_cmd_addr, mem_cmd_we, mem_din);
        end
        tick();
        ibus_cmd_addr = 32'h104;
        sample();
        total++;
        if (hs_out() !== 6'b000000) begin
            bad++; $display("FAIL fetch_wait: got %b want 000000", hs_out());
        end
        tick();
        mem_valid = 1; mem_dout = 32'hDEAD0001; ibus_ready = 1;
        sample();
        total++;
        if ({hs_out(), ibus_dout} !== {6'b010100, 32'hDEAD0001}) begin
            bad++; $display("FAIL fetch_rsp: got %b/%h want 010100/dead0001", hs_out(), ibus_dout);
        end
        tick();
        mem_valid = 0; mem_cmd_ready = 0;
        sample();
        total++;
        if ({hs_out(), mem_cmd_addr} !== {6'b100000, 32'h104}) begin
            bad++; $display("FAIL fetch_back_idle: got %b/%h want 100000/00000104", hs_out(), mem_cmd_addr);
        end
        tick(); clear_inputs();
    endtask

    task automatic test_priority();
        logic          exp_d;
        logic [31:0]   rdata;
        logic [31:0]   got;
        rst = 1; tick(); rst = 0;
        for (int r = 0; r < 5; r++) begin
            clear_inputs();
            ibus_cmd_valid = 1; ibus_cmd_addr = 32'h300 + 32'(r * 4);
            dbus_cmd_valid = (r < 4); dbus_cmd_addr = 32'h200 + 32'(r * 4);
            mem_cmd_ready = 1;
            exp_d = (r < 4) && (!RR || (r % 2 == 1));
            sample();
            total++;
            if ({hs_out(), mem_cmd_addr} !== {(exp_d ? 6'b100010 : 6'b101000),
                                               (exp_d ? dbus_cmd_addr : ibus_cmd_addr)}) begin
                bad++; $display("FAIL prio_grant_%0d: got %b/%h want dbus=%0d", r, hs_out(), mem_cmd_addr, exp_d);
            end
            tick();
            rdata = $urandom;
            mem_valid = 1; mem_dout = rdata; ibus_ready = 1; dbus_ready = 1;
            sample();
            got = exp_d ? dbus_dout : ibus_dout;
            total++;
            if ({hs_out(), got} !== {(exp_d ? 6'b010001 : 6'b010100), rdata}) begin
                bad++; $display("FAIL prio_rsp_%0d: got %b/%h want dbus=%0d data %h", r, hs_out(), got, exp_d, rdata);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_flush_drain();
        ibus_cmd_valid = 1; ibus_cmd_addr = 32'h400; mem_cmd_ready = 1;
        sample();
        total++;
        if (hs_out() !== 6'b101000) begin
            bad++; $display("FAIL drain_cmd: got %b want 101000", hs_out());
        end
        tick();
        clear_inputs(); ibus_flush_req = 1;
        sample();
        total++;
        if (ibus_valid !== 1'b0) begin
            bad++; $display("FAIL drain_flush_valid: got %b want 0", ibus_valid);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            clear_inputs(); ibus_ready = 1; ibus_flush_req = (k == 1);
            sample();
            total++;
            if (hs_out() !== 6'b010000) begin
                bad++; $display("FAIL drain_wait_%0d: got %b want 010000", k, hs_out());
            end
            tick();
        end
        clear_inputs();
        mem_valid = 1; mem_dout = $urandom; ibus_ready = 1;
        ibus_cmd_valid = 1; ibus_cmd_addr = 32'h500; mem_cmd_ready = 1;
        sample();
        total++;
        if (hs_out() !== 6'b010000) begin
            bad++; $display("FAIL drain_discard: got %b want 010000", hs_out());
        end
        tick();
        mem_valid = 0;
        sample();
        total++;
        if ({hs_out(), mem_cmd_addr} !== {6'b101000, 32'h500}) begin
            bad++; $display("FAIL drain_next_cmd: got %b/%h want 101000/00000500", hs_out(), mem_cmd_addr);
        end
        tick();
        clear_inputs(); mem_valid = 1; mem_dout = 32'hCAFE0500; ibus_ready = 1;
        sample();
        total++;
        if ({hs_out(), ibus_dout} !== {6'b010100, 32'hCAFE0500}) begin
            bad++; $display("FAIL drain_next_rsp: got %b/%h want 010100/cafe0500", hs_out(), ibus_dout);
        end
        tick(); clear_inputs();
    endtask

    task automatic test_flush_same_cycle();
        ibus_cmd_valid = 1; ibus_cmd_addr = 32'h600; mem_cmd_ready = 1;
        sample();
        tick();
        clear_inputs(); ibus_flush_req = 1; mem_valid = 1; mem_dout = $urandom;
        sample();
        total++;
        if (hs_out() !== 6'b010000) begin
            bad++; $display("FAIL flush_same: got %b want 010000", hs_out());
        end
        tick();
        clear_inputs(); ibus_flush_req = 1;
        ibus_cmd_valid = 1; ibus_cmd_addr = 32'h700; mem_cmd_ready = 1;
        sample();
        total++;
        if ({hs_out(), mem_cmd_addr} !== {6'b101000, 32'h700}) begin
            bad++; $display("FAIL flush_idle_cmd: got %b/%h want 101000/00000700", hs_out(), mem_cmd_addr);
        end
        tick();
        clear_inputs(); mem_valid = 1; mem_dout = 32'h0000_0777; ibus_ready = 1;
        sample();
        total++;
        if ({hs_out(), ibus_dout} !== {6'b010100, 32'h0000_0777}) begin
            bad++; $display("FAIL flush_idle_rsp: got %b/%h want 010100/00000777", hs_out(), ibus_dout);
        end
        tick(); clear_inputs();
    endtask

    task automatic test_store_backpressure();
        dbus_cmd_valid = 1; dbus_cmd_addr = 32'h800; dbus_cmd_we = 4'hF;
        dbus_din = 32'h12345678; mem_cmd_ready = 1;
        sample();
        total++;
        if ({hs_out(), mem_cmd_addr, mem_cmd_we, mem_din} !== {6'b100010, 32'h800, 4'hF, 32'h12345678}) begin
            bad++; $display("FAIL store_cmd: got %b/%h/%h/%h want 100010/00000800/f/12345678",
                            hs_out(), mem_cmd_addr, mem_cmd_we, mem_din);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            clear_inputs(); mem_valid = 1; ibus_flush_req = 1;
            sample();
            total++;
            if (hs_out() !== 6'b000001) begin
                bad++; $display("FAIL store_hold_%0d: got %b want 000001", k, hs_out());
            end
            tick();
        end
        dbus_ready = 1;
        sample();
        total++;
        if (hs_out() !== 6'b010001) begin
            bad++; $display("FAIL store_ack: got %b want 010001", hs_out());
        end
        tick();
        clear_inputs(); dbus_cmd_valid = 1; dbus_cmd_addr = 32'h804;
        sample();
        total++;
        if (hs_out() !== 6'b100000) begin
            bad++; $display("FAIL store_after: got %b want 100000", hs_out());
        end
        tick(); clear_inputs();
    endtask

    task automatic test_reset_mid();
        dbus_cmd_valid = 1; dbus_cmd_addr = 32'h880; mem_cmd_ready = 1;
        sample();
        tick();
        rst = 1;
        ibus_cmd_valid = 1; mem_valid = 1; dbus_ready = 1; ibus_ready = 1;
        sample();
        total++;
        if (hs_out() !== 6'b000000) begin
            bad++; $display("FAIL rst_mid: got %b want 000000", hs_out());
        end
        tick();
        rst = 0; clear_inputs();
        ibus_cmd_valid = 1; ibus_cmd_addr = 32'h900;
        sample();
        total++;
        if ({hs_out(), mem_cmd_addr} !== {6'b100000, 32'h900}) begin
            bad++; $display("FAIL rst_mid_idle: got %b/%h want 100000/00000900", hs_out(), mem_cmd_addr);
        end
        tick(); clear_inputs();
    endtask

    // Transaction-level model: pending requests, one owner, a word memory.
    task automatic test_random();
        logic [31:0] mem_arr [16];
        logic        pend_i, pend_d, win_d, exp_cv, exp_mrdy, rr_d;
        logic [31:0] ai, ad, dd, exp_data, got;
        logic [3:0]  wd;
        logic [5:0]  exp_hs, got_hs;
        int          owner, lat, idx;
        rst = 1; tick(); rst = 0; clear_inputs();
        for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
        pend_i = 0; pend_d = 0; owner = 0; lat = 0; rr_d = 0;
        ai = '0; ad = '0; dd = '0; wd = '0; exp_data = '0; idx = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1; ai = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            end
            if (!pend_d && $urandom_range(0, 2) == 0) begin
                pend_d = 1; ad = 32'h2000 + 32'($urandom_range(0, 15)) * 4;
                wd = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0; dd = $urandom;
            end
            ibus_cmd_valid = pend_i; ibus_cmd_addr = ai;
            dbus_cmd_valid = pend_d; dbus_cmd_addr = ad; dbus_cmd_we = wd; dbus_din = dd;
            mem_cmd_ready = ($urandom_range(0, 3) != 0);
            ibus_ready = ($urandom_range(0, 3) != 0);
            dbus_ready = ($urandom_range(0, 3) != 0);
            mem_valid = (owner != 0) && (lat == 0);
            mem_dout = mem_valid ? mem_arr[idx] : $urandom;
            sample();
            win_d = pend_d && (!pend_i || !RR || rr_d);
            exp_cv = (owner == 0) && (pend_i || pend_d);
            exp_mrdy = (owner == 1) ? ibus_ready : (owner == 2) ? dbus_ready : 1'b0;
            exp_hs = {exp_cv, exp_mrdy,
                      exp_cv && !win_d && mem_cmd_ready, (owner == 1) && mem_valid,
                      exp_cv && win_d && mem_cmd_ready, (owner == 2) && mem_valid};
            got_hs = {mem_cmd_valid, mem_ready, ibus_cmd_ready & ibus_cmd_valid, ibus_valid,
                      dbus_cmd_ready & dbus_cmd_valid, dbus_valid};
            total++;
            if (got_hs !== exp_hs) begin
                bad++; $display("FAIL rand_hs cyc %0d: got %b want %b", cyc, got_hs, exp_hs);
            end
            if (exp_cv) begin
                total++;
                if ({mem_cmd_addr, mem_cmd_we, mem_din} !== (win_d ? {ad, wd, dd} : {ai, 4'h0, 32'h0})) begin
                    bad++; $display("FAIL rand_cmd cyc %0d: got %h/%h/%h dbus=%0d", cyc,
                                    mem_cmd_addr, mem_cmd_we, mem_din, win_d);
                end
            end
            if (owner != 0 && mem_valid) begin
                got = (owner == 1) ? ibus_dout : dbus_dout;
                total++;
                if (got !== exp_data) begin
                    bad++; $display("FAIL rand_data cyc %0d: got %h want %h", cyc, got, exp_data);
                end
            end
            if (exp_cv && mem_cmd_ready) begin
                owner = win_d ? 2 : 1;
                idx = win_d ? int'(ad[5:2]) : int'(ai[5:2]);
                if (win_d) begin
                    for (int b = 0; b < 4; b++)
                        if (wd[b]) mem_arr[idx][8*b +: 8] = dd[8*b +: 8];
                    pend_d = 0;
                end else begin
                    pend_i = 0;
                end
                exp_data = mem_arr[idx];
                lat = $urandom_range(0, 3);
                rr_d = !win_d;
            end else if (owner != 0) begin
                if (mem_valid && exp_mrdy) owner = 0;
                else if (lat > 0) lat--;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        tick(); tick();
        test_reset();
        test_ibus_fetch();
        test_priority();
        test_flush_drain();
        test_flush_same_cycle();
        test_store_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
